// File: rtl/spike_rate_decoder_if.sv
// Bundles the spike input, window control and rate/ISI result handshake of spike_rate_decoder.
// master is the decoder side; slave is the spike source / result consumer side.
interface spike_rate_decoder_if #(
  parameter int WIN_W = 8,
  parameter int CNT_W = 8
);
  logic             spike;
  logic             enable;
  logic [WIN_W-1:0] window_len;
  logic [CNT_W-1:0] rate;
  logic             rate_valid;
  logic             rate_ready;
  logic [CNT_W-1:0] isi;
  logic             overflow;
  logic             clear_ovf;

  modport master (
    input  spike, enable, window_len, rate_ready, clear_ovf,
    output rate, rate_valid, isi, overflow
  );

  modport slave (
    output spike, enable, window_len, rate_ready, clear_ovf,
    input  rate, rate_valid, isi, overflow
  );
endinterface

// File: rtl/spike_rate_decoder.sv
// Counts spikes over programmable windows, queues each window count in a small FIFO,
// and tracks the most recent inter-spike interval.
module spike_rate_decoder #(
  parameter int WIN_W = 8,
  parameter int CNT_W = 8,
  parameter int DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst,
  spike_rate_decoder_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, COUNT} state_e;

  state_e           state_q, state_d;
  logic [WIN_W-1:0] last_q, last_d;
  logic [WIN_W-1:0] cyc_q, cyc_d;
  logic [WIN_W-1:0] len_m1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] result;
  logic             push;

  logic [CNT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      occ_q;
  logic             full, pop, push_ok, ovf_set;

  logic [CNT_W-1:0] gap_q, gap_inc, isi_q;
  logic             ovf_q;

  // Window length is kept as L-1 so the closing compare needs no subtractor.
  assign len_m1 = (bus.window_len == '0) ? '0 : bus.window_len - 1'b1;
  assign result = (bus.spike && cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cyc_d   = cyc_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.enable) begin
          state_d = COUNT;
          last_d  = len_m1;
          cyc_d   = '0;
          cnt_d   = '0;
        end
      end
      COUNT: begin
        if (cyc_q == last_q) begin
          push    = 1'b1;
          cyc_d   = '0;
          cnt_d   = '0;
          last_d  = len_m1;
          state_d = bus.enable ? COUNT : IDLE;
        end else if (!bus.enable) begin
          state_d = IDLE;
          cyc_d   = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = result;
          cyc_d = cyc_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign full    = (occ_q == OCC_FULL);
  assign pop     = (occ_q != '0) && bus.rate_ready;
  assign push_ok = push && (!full || pop);
  assign ovf_set = push && full && !pop;
  assign gap_inc = (gap_q == CNT_MAX) ? CNT_MAX : gap_q + 1'b1;

  // NOTE: state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= '0;
      cyc_q   <= '0;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      occ_q   <= '0;
      gap_q   <= CNT_MAX;
      isi_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cyc_q   <= cyc_d;
      cnt_q   <= cnt_d;
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop)     rd_q <= rd_q + 1'b1;
      unique case ({push_ok, pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
      if (bus.spike) begin
        isi_q <= gap_inc;
        gap_q <= '0;
      end else begin
        gap_q <= gap_inc;
      end
      if (ovf_set)            ovf_q <= 1'b1;
      else if (bus.clear_ovf) ovf_q <= 1'b0;
    end
  end

  // NOTE: storage is not reset; the occupancy counter alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= result;
  end

  assign bus.rate       = (occ_q != '0) ? mem_q[rd_q] : '0;
  assign bus.rate_valid = (occ_q != '0);
  assign bus.isi        = isi_q;
  assign bus.overflow   = ovf_q;

endmodule
